// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequenced ALU front-end (alu_seq) and its latency
// counter (alu_lat_cnt).
//   - Opcode constants ALU_OP_AND (0) .. ALU_OP_DIV (14), ALU_OP_LAST = 14
//   - LAT_WIDTH : width of the EXEC latency counter (latencies 1..15)
//   - alu_state_t : IDLE / EXEC / RESP sequencer states
//   - lat_clip() : folds a configured cycle count into the legal 1..15 range
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned ALU_OP_AND  = 0;
    localparam int unsigned ALU_OP_OR   = 1;
    localparam int unsigned ALU_OP_XOR  = 2;
    localparam int unsigned ALU_OP_NOR  = 3;
    localparam int unsigned ALU_OP_NOT  = 4;
    localparam int unsigned ALU_OP_SLL  = 5;
    localparam int unsigned ALU_OP_SRL  = 6;
    localparam int unsigned ALU_OP_SRA  = 7;
    localparam int unsigned ALU_OP_ANDN = 8;
    localparam int unsigned ALU_OP_ORN  = 9;
    localparam int unsigned ALU_OP_SLT  = 10;
    localparam int unsigned ALU_OP_ADD  = 11;
    localparam int unsigned ALU_OP_SUB  = 12;
    localparam int unsigned ALU_OP_MUL  = 13;
    localparam int unsigned ALU_OP_DIV  = 14;
    localparam int unsigned ALU_OP_LAST = 14;

    localparam int unsigned LAT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_state_t;

    // A zero latency would never raise the last flag, so out-of-range
    // configurations are folded into 1..15 rather than hanging the sequencer.
    function automatic logic [LAT_WIDTH-1:0] lat_clip(input int unsigned cycles);
        logic [LAT_WIDTH-1:0] res;
        if (cycles < 32'd1) begin
            res = 4'd1;
        end else if (cycles > 32'd15) begin
            res = 4'd15;
        end else begin
            res = LAT_WIDTH'(cycles);
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_lat_cnt.sv
// -----------------------------------------------------------------------------
// alu_lat_cnt
// EXEC-phase latency down-counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count cleared to 0)
//   load       : load load_val (has priority over dec)
//   load_val   : number of EXEC cycles for the accepted operation
//   dec        : decrement by one (saturates at 0)
//   last       : count == 1, i.e. the current EXEC cycle is the final one
// -----------------------------------------------------------------------------
module alu_lat_cnt
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LAT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 last
);

    localparam logic [LAT_WIDTH-1:0] CNT_ZERO = {LAT_WIDTH{1'b0}};
    localparam logic [LAT_WIDTH-1:0] CNT_ONE  = {{(LAT_WIDTH-1){1'b0}}, 1'b1};

    logic [LAT_WIDTH-1:0] cnt_r;

    // Counter register: load wins over decrement, decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == CNT_ONE);

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequences single requests through an external combinational/multi-cycle ALU:
// accept in IDLE, hold operands on alu_* for the op's EXEC latency, capture the
// ALU result halves, then present them until the consumer takes them.
// Optional feature macro: ALU_SEQ_DIV0_TRAP_EN -- when defined, DIV (op 14)
// with req_b == 0 is trapped: one EXEC cycle, zero result, rsp_wide=1,
// rsp_err=1. When undefined, DIV by zero runs DIV_CYCLES and passes the ALU
// output through with rsp_err=0.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_op, req_a, req_b        : select code and operands
//   alu_a, alu_b, alu_sel       : operands/select held for the external ALU
//   alu_zhigh, alu_zlow         : external ALU result halves
//   rsp_valid/rsp_ready         : response handshake
//   rsp_zhigh, rsp_zlow         : captured result
//   rsp_wide                    : result is a HI/LO pair (MUL, DIV)
//   rsp_err                     : illegal op (op > 14) or divide-by-zero trap
//   busy                        : sequencer not in IDLE
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 16,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEL_WIDTH-1:0]  req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [SEL_WIDTH-1:0]  alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_zhigh,
    input  logic [DATA_WIDTH-1:0] alu_zlow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_zhigh,
    output logic [DATA_WIDTH-1:0] rsp_zlow,
    output logic                  rsp_wide,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam logic [SEL_WIDTH-1:0]  OP_LAST_C = SEL_WIDTH'(ALU_OP_LAST);
    localparam logic [SEL_WIDTH-1:0]  OP_MUL_C  = SEL_WIDTH'(ALU_OP_MUL);
    localparam logic [SEL_WIDTH-1:0]  OP_DIV_C  = SEL_WIDTH'(ALU_OP_DIV);
    localparam logic [LAT_WIDTH-1:0]  LAT_ONE_C = {{(LAT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LAT_WIDTH-1:0]  MUL_LAT_C = lat_clip(MUL_CYCLES);
    localparam logic [LAT_WIDTH-1:0]  DIV_LAT_C = lat_clip(DIV_CYCLES);
    localparam logic [DATA_WIDTH-1:0] ZERO_C    = {DATA_WIDTH{1'b0}};

    alu_state_t            state_r;
    alu_state_t            state_s;
    logic                  load_s;
    logic                  dec_s;
    logic                  cnt_last_s;
    logic                  finish_s;
    logic                  consume_s;
    logic [LAT_WIDTH-1:0]  lat_s;
    logic                  err_s;
    logic                  wide_s;

    logic                  err_pend_r;
    logic                  wide_pend_r;
    logic [DATA_WIDTH-1:0] alu_a_r;
    logic [DATA_WIDTH-1:0] alu_b_r;
    logic [SEL_WIDTH-1:0]  alu_sel_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_zhigh_r;
    logic [DATA_WIDTH-1:0] rsp_zlow_r;
    logic                  rsp_wide_r;
    logic                  rsp_err_r;
    logic                  busy_r;
    logic                  req_ready_r;

    // Request classification: EXEC latency and the flags the response will carry.
    always_comb begin
        lat_s  = LAT_ONE_C;
        err_s  = 1'b0;
        wide_s = 1'b0;
        if (req_op > OP_LAST_C) begin
            lat_s = LAT_ONE_C;
            err_s = 1'b1;
        end else if (req_op == OP_MUL_C) begin
            lat_s  = MUL_LAT_C;
            wide_s = 1'b1;
        end else if (req_op == OP_DIV_C) begin
            wide_s = 1'b1;
`ifdef ALU_SEQ_DIV0_TRAP_EN
            if (req_b == ZERO_C) begin
                lat_s = LAT_ONE_C;
                err_s = 1'b1;
            end else begin
                lat_s = DIV_LAT_C;
                err_s = 1'b0;
            end
`else
            lat_s = DIV_LAT_C;
`endif
        end else begin
            lat_s = LAT_ONE_C;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and control strobes. Acceptance uses the registered ready so
    // nothing is taken on the first edge after reset release, when ready is
    // still low.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        dec_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    state_s = ST_EXEC;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                dec_s = 1'b1;
                if (cnt_last_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign finish_s  = dec_s && cnt_last_s;
    assign consume_s = (state_r == ST_RESP) && rsp_ready;

    alu_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_val (lat_s),
        .dec      (dec_s),
        .last     (cnt_last_s)
    );

    // Operand/select capture at accept and result capture on the last EXEC
    // cycle; a trapped or illegal op returns zeros instead of the ALU output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r     <= ZERO_C;
            alu_b_r     <= ZERO_C;
            alu_sel_r   <= {SEL_WIDTH{1'b0}};
            err_pend_r  <= 1'b0;
            wide_pend_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_zhigh_r <= ZERO_C;
            rsp_zlow_r  <= ZERO_C;
            rsp_wide_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            if (load_s) begin
                alu_a_r     <= req_a;
                alu_b_r     <= req_b;
                alu_sel_r   <= req_op;
                err_pend_r  <= err_s;
                wide_pend_r <= wide_s;
            end
            if (finish_s) begin
                rsp_valid_r <= 1'b1;
                rsp_zhigh_r <= err_pend_r ? ZERO_C : alu_zhigh;
                rsp_zlow_r  <= err_pend_r ? ZERO_C : alu_zlow;
                rsp_wide_r  <= wide_pend_r;
                rsp_err_r   <= err_pend_r;
            end else if (consume_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    // Status outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            req_ready_r <= 1'b0;
        end else begin
            busy_r      <= (state_s != ST_IDLE);
            req_ready_r <= (state_s == ST_IDLE);
        end
    end

    assign req_ready = req_ready_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sel   = alu_sel_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_zhigh = rsp_zhigh_r;
    assign rsp_zlow  = rsp_zlow_r;
    assign rsp_wide  = rsp_wide_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq with default parameters. A behavioural ALU
// drives alu_zhigh/alu_zlow from the DUT's alu_* outputs; expected responses
// and latencies are computed from each request's op and operands.
// Honours ALU_SEQ_DIV0_TRAP_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int DW = 32;
    localparam int SW = 16;
    localparam int MULC = 4;
    localparam int DIVC = 8;
`ifdef ALU_SEQ_DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [SW-1:0] req_op;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [SW-1:0] alu_sel;
    logic [DW-1:0] alu_zhigh;
    logic [DW-1:0] alu_zlow;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_zhigh;
    logic [DW-1:0] rsp_zlow;
    logic          rsp_wide;
    logic          rsp_err;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    // Last response observed by run_op, for directed constant checks.
    logic [DW-1:0] last_hi;
    logic [DW-1:0] last_lo;
    logic          last_wide;
    logic          last_err;
    int            last_lat;

    alu_seq #(
        .DATA_WIDTH (DW),
        .SEL_WIDTH  (SW),
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_zhigh (alu_zhigh),
        .alu_zlow  (alu_zlow),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_zhigh (rsp_zhigh),
        .rsp_zlow  (rsp_zlow),
        .rsp_wide  (rsp_wide),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {hi, lo}. MUL is signed 32x32->64, DIV gives
    // hi = remainder, lo = quotient (b == 0: hi = a, lo = all ones).
    function automatic logic [63:0] ref_alu(input logic [SW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] p;
        hi = 32'd0;
        lo = 32'd0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            16'd0:  lo = a & b;
            16'd1:  lo = a | b;
            16'd2:  lo = a ^ b;
            16'd3:  lo = ~(a | b);
            16'd4:  lo = ~a;
            16'd5:  lo = a << b[4:0];
            16'd6:  lo = a >> b[4:0];
            16'd7:  lo = $unsigned($signed(a) >>> b[4:0]);
            16'd8:  lo = a & ~b;
            16'd9:  lo = a | ~b;
            16'd10: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            16'd11: lo = a + b;
            16'd12: lo = a - b;
            16'd13: begin
                p  = $unsigned(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            16'd14: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
            default: begin
                hi = 32'd0;
                lo = 32'd0;
            end
        endcase
        return {hi, lo};
    endfunction

    always_comb {alu_zhigh, alu_zlow} = ref_alu(alu_sel, alu_a, alu_b);

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete transaction: accept, wait for response (checking latency and
    // operand hold), hold rsp_ready low for 'hold' cycles (optionally poking a
    // second request that must be ignored), then consume.
    task automatic run_op(input logic [SW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int hold, input bit poke);
        int            cyc;
        int            exp_lat;
        bit            exp_err;
        bit            exp_wide;
        logic [63:0]   exp_z;
        logic [DW-1:0] h0;
        logic [DW-1:0] l0;

        exp_wide = (op == 16'd13) || (op == 16'd14);
        exp_err  = (op > 16'd14) || (TRAP && op == 16'd14 && b == 32'd0);
        if (op == 16'd13)                 exp_lat = MULC;
        else if (op == 16'd14 && !exp_err) exp_lat = DIVC;
        else                              exp_lat = 1;
        exp_z = exp_err ? 64'd0 : ref_alu(op, a, b);

        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("ready_before_req", {63'd0, req_ready}, 64'd1);

        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = $urandom();
        req_a     = $urandom();
        req_b     = $urandom();
        check_val("busy_after_accept", {63'd0, busy}, 64'd1);
        check_val("ready_low_in_exec", {63'd0, req_ready}, 64'd0);

        // cycle 0 is the accept cycle; we are now in cycle 1
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            check_val("alu_sel_held", {48'd0, alu_sel}, {48'd0, op});
            check_val("alu_ab_held", {alu_a, alu_b}, {a, b});
            @(negedge clk);
            cyc++;
        end
        last_lat = cyc;
        check_val("rsp_latency", 64'(cyc), 64'(exp_lat + 1));
        check_val("rsp_data", {rsp_zhigh, rsp_zlow}, exp_z);
        check_val("rsp_wide", {63'd0, rsp_wide}, {63'd0, exp_wide});
        check_val("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
        h0        = rsp_zhigh;
        l0        = rsp_zlow;
        last_hi   = rsp_zhigh;
        last_lo   = rsp_zlow;
        last_wide = rsp_wide;
        last_err  = rsp_err;

        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1;
                req_op    = op ^ 16'd1;
            end
            @(negedge clk);
            check_val("hold_valid", {63'd0, rsp_valid}, 64'd1);
            check_val("hold_data", {rsp_zhigh, rsp_zlow}, {h0, l0});
            check_val("hold_ready_low", {63'd0, req_ready}, 64'd0);
            check_val("hold_alu_a", {32'd0, alu_a}, {32'd0, a});
        end
        req_valid = 1'b0;

        rsp_ready = 1'b1;
        check_val("completion_ready_low", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("valid_drop", {63'd0, rsp_valid}, 64'd0);
        check_val("idle_ready", {63'd0, req_ready}, 64'd1);
        check_val("idle_busy", {63'd0, busy}, 64'd0);
        if (poke) begin
            @(negedge clk);
            check_val("poke_not_queued", {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {alu_a, alu_b}, 64'd0);
        check_val(tag, {48'd0, alu_sel}, 64'd0);
        check_val(tag, {rsp_zhigh, rsp_zlow}, 64'd0);
        check_val(tag, {59'd0, rsp_valid, rsp_wide, rsp_err, busy, req_ready}, 64'd0);
    endtask

    initial begin
        int bad;
        logic [SW-1:0] op;
        logic [DW-1:0] b;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 16'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        #1;
        check_val("ready_before_first_edge", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        check_val("ready_after_first_edge", {63'd0, req_ready}, 64'd1);

        // ADD 5 + 7
        run_op(16'd11, 32'd5, 32'd7, 0, 1'b0);
        check_val("add_lo", {32'd0, last_lo}, 64'd12);
        check_val("add_hi", {32'd0, last_hi}, 64'd0);
        check_val("add_wide", {63'd0, last_wide}, 64'd0);
        check_val("add_lat", 64'(last_lat), 64'd2);

        // signed MUL -1 * 2
        run_op(16'd13, 32'hFFFF_FFFF, 32'd2, 1, 1'b0);
        check_val("mul_z", {last_hi, last_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("mul_wide", {63'd0, last_wide}, 64'd1);
        check_val("mul_lat", 64'(last_lat), 64'd5);

        // illegal op 15
        run_op(16'd15, 32'd3, 32'd4, 0, 1'b0);
        check_val("illegal_z", {last_hi, last_lo}, 64'd0);
        check_val("illegal_err", {63'd0, last_err}, 64'd1);
        check_val("illegal_lat", 64'(last_lat), 64'd2);

        // back-pressure: rsp_ready low for 10 cycles with a second request poked
        run_op(16'd12, 32'd100, 32'd1, 10, 1'b1);

        // DIV by zero
        run_op(16'd14, 32'd9, 32'd0, 0, 1'b0);
        check_val("div0_err", {63'd0, last_err}, {63'd0, TRAP});
        check_val("div0_wide", {63'd0, last_wide}, 64'd1);
        check_val("div0_lat", 64'(last_lat), TRAP ? 64'd2 : 64'd9);
        check_val("div0_z", {last_hi, last_lo},
                  TRAP ? 64'd0 : {32'd9, 32'hFFFF_FFFF});

        // reset during EXEC of a DIV
        req_valid = 1'b1;
        req_op    = 16'd14;
        req_a     = 32'd100;
        req_b     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("div_in_exec", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_exec");
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check_val("no_rsp_after_reset", 64'(bad), 64'd0);
        run_op(16'd14, 32'd100, 32'd7, 0, 1'b0);
        check_val("div_after_reset", {last_hi, last_lo}, {32'd2, 32'd14});

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) op = 16'($urandom_range(15, 65535));
            else                            op = 16'($urandom_range(0, 14));
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
            run_op(op, $urandom(), b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before limit");
        $fatal(1, "time limit");
    end

endmodule
